writeback_stage: RTL and testbench

- Write-back producer that drives the register file's single write port (write_enable, rd, WBSel, PC, ALU_out, dmem_out).
- Accepts retiring instructions from the memory stage through a valid/ready handshake.
- Buffers them in a small in-order queue and waits for load data from the synchronous data memory, which has a fixed 1-cycle latency.
- Issues at most one register write per cycle and exports pending-write status so decode can detect hazards.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/writeback_stage_if.sv | 39 +++
 rtl/load_extend.sv | 31 +++
 rtl/writeback_stage.sv | 113 +++++++++++
 tb/tb_writeback_stage.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants and entry-state type for the write-back stage.
package wb_pkg;

   // Write-back source select
   localparam logic [1:0] WB_DMEM = 2'd0;
   localparam logic [1:0] WB_ALU  = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

   // Load size/sign encodings (funct3)
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   typedef enum logic [1:0] {
      EMPTY     = 2'd0,
      WAIT_DATA = 2'd1,
      READY     = 2'd2
   } entry_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of the memory-stage handshake, load data, register-file write
// port and hazard query signals of the write-back stage.
interface writeback_stage_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic            in_reg_write;
   logic [4:0]      in_rd;
   logic [1:0]      in_WBSel;
   logic [XLEN-1:0] in_PC;
   logic [XLEN-1:0] in_ALU_out;
   logic [2:0]      in_funct3;
   logic [XLEN-1:0] dmem_rdata;
   logic            write_enable;
   logic [4:0]      rd;
   logic [1:0]      WBSel;
   logic [XLEN-1:0] PC;
   logic [XLEN-1:0] ALU_out;
   logic [XLEN-1:0] dmem_out;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            rs1_busy;
   logic            rs2_busy;

   // Upstream / environment side
   modport master (
      output in_valid, in_reg_write, in_rd, in_WBSel, in_PC, in_ALU_out,
             in_funct3, dmem_rdata, rs1, rs2,
      input  in_ready, write_enable, rd, WBSel, PC, ALU_out, dmem_out,
             rs1_busy, rs2_busy
   );

   // Write-back stage side
   modport slave (
      input  in_valid, in_reg_write, in_rd, in_WBSel, in_PC, in_ALU_out,
             in_funct3, dmem_rdata, rs1, rs2,
      output in_ready, write_enable, rd, WBSel, PC, ALU_out, dmem_out,
             rs1_busy, rs2_busy
   );
endinterface

// File: rtl/load_extend.sv
// Combinational sub-word load extraction: selects the byte/halfword at
// addr_lo and sign- or zero-extends it. Misaligned halfwords take bytes
// addr..addr+1 of the word (upper byte reads 0 past the word end).
module load_extend
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] ext
);

   logic [XLEN-1:0] sh;

   assign sh = word >> {addr_lo, 3'b000};

   // Size/sign select
   always_comb begin
      ext = word;
      case (funct3)
         F3_LB:   ext = {{(XLEN-8){sh[7]}}, sh[7:0]};
         F3_LH:   ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
         F3_LBU:  ext = {{(XLEN-8){1'b0}}, sh[7:0]};
         F3_LHU:  ext = {{(XLEN-16){1'b0}}, sh[15:0]};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// In-order write-back queue driving the register file write port.
// Loads wait one cycle for synchronous dmem data; everything else is
// ready immediately. Optional macro LOAD_EXT_EN enables sub-word load
// extraction; without it load data is passed through as a full word.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input logic              clk,
   input logic              rst,
   writeback_stage_if.slave bus
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      entry_state_e    st;
      logic [4:0]      rd;
      logic [1:0]      wbsel;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] data;
      logic [2:0]      f3;
   } entry_t;

   entry_t                      q [DEPTH];
   logic [PW-1:0]               head, tail;
   logic [PW:0]                 count;
   logic [DEPTH-1:0][XLEN-1:0]  ext;
   logic                        acc, enq, pop;
   logic                        rs1_hit, rs2_hit;

   assign bus.in_ready = (count < (PW+1)'(DEPTH));
   assign acc = bus.in_valid && bus.in_ready;
   assign enq = acc && bus.in_reg_write && (bus.in_rd != 5'd0);
   assign pop = (q[head].st == READY);

   // Only the WAIT_DATA entry consumes ext[i]; there is at most one.
`ifdef LOAD_EXT_EN
   for (genvar i = 0; i < DEPTH; i++) begin : g_ext
      load_extend #(.XLEN(XLEN)) u_ext (
         .word    (bus.dmem_rdata),
         .addr_lo (q[i].alu[1:0]),
         .funct3  (q[i].f3),
         .ext     (ext[i])
      );
   end
`else
   // Word-only loads: data passes through untouched
   always_comb begin
      for (int i = 0; i < DEPTH; i++) ext[i] = bus.dmem_rdata;
   end
`endif

   // Write port comes straight from the head entry's registers
   assign bus.write_enable = pop;
   assign bus.rd           = q[head].rd;
   assign bus.WBSel        = q[head].wbsel;
   assign bus.PC           = q[head].pc;
   assign bus.ALU_out      = q[head].alu;
   assign bus.dmem_out     = q[head].data;

   // Hazard scan over every occupied entry, issuing head included
   always_comb begin
      rs1_hit = 1'b0;
      rs2_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (q[i].st != EMPTY) begin
            if (q[i].rd == bus.rs1) rs1_hit = 1'b1;
            if (q[i].rd == bus.rs2) rs2_hit = 1'b1;
         end
      end
   end

   assign bus.rs1_busy = rs1_hit && (bus.rs1 != 5'd0);
   assign bus.rs2_busy = rs2_hit && (bus.rs2 != 5'd0);

   // Entry state machine, pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (enq && tail == PW'(i)) begin
               q[i].st    <= (bus.in_WBSel == WB_DMEM) ? WAIT_DATA : READY;
               q[i].rd    <= bus.in_rd;
               q[i].wbsel <= bus.in_WBSel;
               q[i].pc    <= bus.in_PC;
               q[i].alu   <= bus.in_ALU_out;
               q[i].f3    <= bus.in_funct3;
            end else if (q[i].st == WAIT_DATA) begin
               q[i].st   <= READY;
               q[i].data <= ext[i];
            end else if (pop && head == PW'(i)) begin
               q[i].st <= EMPTY;
            end
         end
         if (pop) head <= head + PW'(1);
         if (enq) tail <= tail + PW'(1);
         case ({enq, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_writeback_stage;
   import wb_pkg::*;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   writeback_stage_if #(.XLEN(XLEN)) bus ();

   writeback_stage #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] data;
      logic [2:0]  f3;
      bit          rdy;
   } mrec_t;

   mrec_t mq[$];
   int    vectors     = 0;
   int    miscompares = 0;
   bit    last_acc;

   // Reference load data: plain shift/mask arithmetic on the word
   function automatic logic [31:0] mext(logic [31:0] w, logic [31:0] a, logic [2:0] f3);
`ifdef LOAD_EXT_EN
      logic [31:0] b;
      b = w >> (8 * (a % 4));
      case (f3)
         3'd0: return ((b & 32'hFF) >= 32'd128) ? ((b & 32'hFF) | 32'hFFFFFF00) : (b & 32'hFF);
         3'd1: return ((b & 32'hFFFF) >= 32'h8000) ? ((b & 32'hFFFF) | 32'hFFFF0000) : (b & 32'hFFFF);
         3'd4: return b & 32'hFF;
         3'd5: return b & 32'hFFFF;
         default: return w;
      endcase
`else
      return (a == a && f3 == f3) ? w : w;
`endif
   endfunction

   function automatic bit m_busy(logic [4:0] rs);
      if (rs == 5'd0) return 1'b0;
      foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [2:0] f3);
      bus.in_valid     = 1'b1;
      bus.in_reg_write = rw;
      bus.in_rd        = rd;
      bus.in_WBSel     = sel;
      bus.in_PC        = pc;
      bus.in_ALU_out   = alu;
      bus.in_funct3    = f3;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   // Called just after a negedge with inputs set: check, clock, update model
   task automatic tick();
      bit we, pop, acc;
      mrec_t n;
      #1;
      we = (mq.size() > 0) && mq[0].rdy;
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      chk("write_enable", 32'(bus.write_enable), 32'(we));
      if (we) begin
         chk("rd", 32'(bus.rd), 32'(mq[0].rd));
         chk("WBSel", 32'(bus.WBSel), 32'(mq[0].sel));
         chk("PC", bus.PC, mq[0].pc);
         chk("ALU_out", bus.ALU_out, mq[0].alu);
         if (mq[0].sel == WB_DMEM) chk("dmem_out", bus.dmem_out, mq[0].data);
      end
      chk("rs1_busy", 32'(bus.rs1_busy), 32'(m_busy(bus.rs1)));
      chk("rs2_busy", 32'(bus.rs2_busy), 32'(m_busy(bus.rs2)));
      @(posedge clk);
      if (rst) begin
         mq.delete();
         last_acc = 1'b0;
      end else begin
         pop = (mq.size() > 0) && mq[0].rdy;
         acc = bus.in_valid && (mq.size() < DEPTH);
         foreach (mq[i]) begin
            if (!mq[i].rdy) begin
               mq[i].rdy  = 1'b1;
               mq[i].data = mext(bus.dmem_rdata, mq[i].alu, mq[i].f3);
            end
         end
         if (pop) void'(mq.pop_front());
         if (acc && bus.in_reg_write && bus.in_rd != 5'd0) begin
            n.rd = bus.in_rd; n.sel = bus.in_WBSel; n.pc = bus.in_PC;
            n.alu = bus.in_ALU_out; n.data = '0; n.f3 = bus.in_funct3;
            n.rdy = (bus.in_WBSel != WB_DMEM);
            mq.push_back(n);
         end
         last_acc = acc;
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      #1;
      chk({tag, "_we"},    32'(bus.write_enable), 32'd0);
      chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_rd"},    32'(bus.rd), 32'd0);
      chk({tag, "_wbsel"}, 32'(bus.WBSel), 32'd0);
      chk({tag, "_pc"},    bus.PC, 32'd0);
      chk({tag, "_alu"},   bus.ALU_out, 32'd0);
      chk({tag, "_dmem"},  bus.dmem_out, 32'd0);
      chk({tag, "_busy1"}, 32'(bus.rs1_busy), 32'd0);
   endtask

   initial begin
      bit pend;
      rst = 1'b1;
      idle();
      bus.in_reg_write = 1'b0; bus.in_rd = '0; bus.in_WBSel = '0;
      bus.in_PC = '0; bus.in_ALU_out = '0; bus.in_funct3 = '0;
      bus.dmem_rdata = '0; bus.rs1 = '0; bus.rs2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      bus.rs1 = 5'd3;
      chk_reset_outputs("rst0");

      // ALU write to x5, busy visible only while queued
      bus.rs1 = 5'd5;
      send(1'b1, 5'd5, WB_ALU, 32'h100, 32'h1234, 3'd0);
      tick();
      idle();
      #1;
      chk("t1_we", 32'(bus.write_enable), 32'd1);
      chk("t1_rd", 32'(bus.rd), 32'd5);
      chk("t1_alu", bus.ALU_out, 32'h1234);
      chk("t1_busy", 32'(bus.rs1_busy), 32'd1);
      tick();
      #1;
      chk("t1_busy_clr", 32'(bus.rs1_busy), 32'd0);
      tick();

      // LW to x7 with ALU to x8 queued behind it
      send(1'b1, 5'd7, WB_DMEM, 32'h200, 32'h1000, F3_LW);
      tick();
      send(1'b1, 5'd8, WB_ALU, 32'h204, 32'h55, 3'd0);
      bus.dmem_rdata = 32'hDEADBEEF;
      tick();
      idle();
      bus.dmem_rdata = 32'h0BADF00D;
      #1;
      chk("t2_we", 32'(bus.write_enable), 32'd1);
      chk("t2_rd", 32'(bus.rd), 32'd7);
      chk("t2_wbsel", 32'(bus.WBSel), 32'd0);
      chk("t2_dmem", bus.dmem_out, 32'hDEADBEEF);
      chk("t2_full", 32'(bus.in_ready), 32'd0);
      tick();
      #1;
      chk("t2_rd8", 32'(bus.rd), 32'd8);
      tick();
      tick();

`ifdef LOAD_EXT_EN
      send(1'b1, 5'd9, WB_DMEM, 32'h300, 32'h1003, F3_LB);
      tick();
      idle();
      bus.dmem_rdata = 32'h80FF0000;
      tick();
      #1;
      chk("lb_ext", bus.dmem_out, 32'hFFFFFF80);
      tick();
      send(1'b1, 5'd9, WB_DMEM, 32'h304, 32'h1002, F3_LHU);
      tick();
      idle();
      bus.dmem_rdata = 32'h80FF0000;
      tick();
      #1;
      chk("lhu_ext", bus.dmem_out, 32'h000080FF);
      tick();
`endif

      // Back-to-back ALU stream x1..x6
      for (int k = 1; k <= 6; k++) begin
         send(1'b1, 5'(k), WB_ALU, 32'(k * 4), 32'(k * 11), 3'd0);
         tick();
      end
      idle();
      repeat (2) tick();

      // Non-writing instructions and x0 destination
      bus.rs1 = 5'd0; bus.rs2 = 5'd9;
      send(1'b0, 5'd9, WB_ALU, 32'h400, 32'h1, 3'd0);
      tick();
      send(1'b1, 5'd0, WB_ALU, 32'h404, 32'h2, 3'd0);
      tick();
      idle();
      #1;
      chk("nowr_we", 32'(bus.write_enable), 32'd0);
      chk("nowr_busy", 32'(bus.rs2_busy), 32'd0);
      tick();

      // Reset while a load waits for data
      bus.rs1 = 5'd10;
      send(1'b1, 5'd10, WB_DMEM, 32'h500, 32'h2000, F3_LW);
      tick();
      idle();
      rst = 1'b1;
      bus.dmem_rdata = 32'hCAFEF00D;
      tick();
      rst = 1'b0;
      chk_reset_outputs("rst1");
      repeat (3) tick();

      // Randomized traffic
      pend = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!pend && $urandom_range(9) < 7) begin
            send($urandom_range(7) != 0, 5'($urandom_range(7)), 2'($urandom_range(2)),
                 $urandom, $urandom, 3'($urandom_range(7)));
            pend = 1'b1;
         end else if (!pend) begin
            idle();
         end
         bus.rs1 = 5'($urandom_range(7));
         bus.rs2 = 5'($urandom_range(7));
         bus.dmem_rdata = $urandom;
         tick();
         if (last_acc) pend = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
